// File: rtl/router_sync_multi.sv
// Destination-port synchroniser between the router FSM, the input register stage
// and NUM_PORTS output FIFOs: address latch/decode, full mux, per-port unread timeout.
module router_sync_multi #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  localparam int CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic                 clr_sticky,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 addr_err,
  output logic [NUM_PORTS-1:0] sft_rst,
  output logic [NUM_PORTS-1:0] timeout_sticky
);

  // One extra bit so NUM_PORTS == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]  PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_vld;
  logic [NUM_PORTS-1:0] sel_oh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      addr_vld <= 1'b0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr_q   <= data_in;
      addr_vld <= 1'b1;
      addr_err <= ({1'b0, data_in} >= PORT_LIMIT);
    end
  end

  // Port handshake: a FIFO offers data while vld_out[k] is high; the consumer
  // takes a word by raising read_enb[k]. Any edge with vld_out[k]=1 and
  // read_enb[k]=0 counts as one unread cycle toward the timeout.
  assign vld_out   = ~empty;
  assign write_enb = sel_oh & {NUM_PORTS{write_enb_reg}};
  assign fifo_full = |(full & sel_oh);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    localparam logic [ADDR_W-1:0] PORT_ID = ADDR_W'(k);

    logic [CNT_W-1:0] cnt;
    logic             fire;
    logic             sft_q;
    logic             sticky_q;

    assign sel_oh[k] = addr_vld && !addr_err && (addr_q == PORT_ID);
    assign fire      = vld_out[k] && !read_enb[k] && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt      <= '0;
        sft_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        if (!vld_out[k] || read_enb[k] || (cnt == CNT_LAST)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        sft_q <= fire;
        // A new timeout outranks a simultaneous clear.
        if (fire) begin
          sticky_q <= 1'b1;
        end else if (clr_sticky) begin
          sticky_q <= 1'b0;
        end
      end
    end

    assign sft_rst[k]        = sft_q;
    assign timeout_sticky[k] = sticky_q;
  end

endmodule

// File: tb/tb_router_sync_multi.sv
// Bench for router_sync_multi: decode table, hand-written timeout/reset sequences,
// a NUM_PORTS=4/TIMEOUT=2 instance, and random traffic against a reference model.
module tb_router_sync_multi;

  localparam int NP = 3;
  localparam int AW = 2;
  localparam int TO = 30;
  localparam int W  = 3 + 1 + 1 + 3 + 3 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          detect_add, write_enb_reg, clr_sticky;
  logic [AW-1:0] data_in;
  logic [NP-1:0] read_enb, full, empty;
  logic [NP-1:0] vld_out, write_enb, sft_rst, timeout_sticky;
  logic          fifo_full, addr_err;

  logic          detect_add4, write_enb_reg4, clr_sticky4;
  logic [1:0]    data_in4;
  logic [3:0]    read_enb4, full4, empty4;
  logic [3:0]    vld_out4, write_enb4, sft_rst4, timeout_sticky4;
  logic          fifo_full4, addr_err4;

  router_sync_multi dut (
    .clk(clk), .rst(rst), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .full(full), .empty(empty),
    .clr_sticky(clr_sticky), .vld_out(vld_out), .write_enb(write_enb),
    .fifo_full(fifo_full), .addr_err(addr_err), .sft_rst(sft_rst),
    .timeout_sticky(timeout_sticky)
  );

  router_sync_multi #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(2)) dut4 (
    .clk(clk), .rst(rst), .detect_add(detect_add4), .data_in(data_in4),
    .write_enb_reg(write_enb_reg4), .read_enb(read_enb4), .full(full4), .empty(empty4),
    .clr_sticky(clr_sticky4), .vld_out(vld_out4), .write_enb(write_enb4),
    .fifo_full(fifo_full4), .addr_err(addr_err4), .sft_rst(sft_rst4),
    .timeout_sticky(timeout_sticky4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_addr;
  bit           m_vld, m_err;
  int           m_run[NP];
  bit [NP-1:0]  m_sft, m_sticky;

  task automatic model_reset();
    m_addr = 0; m_vld = 0; m_err = 0; m_sft = '0; m_sticky = '0;
    for (int k = 0; k < NP; k++) m_run[k] = 0;
  endtask

  // Outputs the DUT should show right now, given current inputs and model state.
  function automatic logic [W-1:0] model_expect();
    logic [NP-1:0] we_e;
    logic          ff_e;
    we_e = '0;
    ff_e = 1'b0;
    if (m_vld && !m_err) begin
      if (write_enb_reg) we_e[m_addr] = 1'b1;
      ff_e = full[m_addr];
    end
    return {we_e, ff_e, m_err, m_sft, m_sticky, ~empty};
  endfunction

  // Advance the model across one rising edge: count consecutive unread edges,
  // pulse when the run reaches TO, then start a fresh run.
  task automatic model_edge();
    bit [NP-1:0] nsft;
    nsft = '0;
    for (int k = 0; k < NP; k++) begin
      if (empty[k] || read_enb[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == TO) begin
          nsft[k]  = 1'b1;
          m_run[k] = 0;
        end
      end
      if (nsft[k]) m_sticky[k] = 1'b1;
      else if (clr_sticky) m_sticky[k] = 1'b0;
    end
    m_sft = nsft;
    if (detect_add) begin
      m_addr = int'(data_in);
      m_vld  = 1'b1;
      m_err  = (int'(data_in) >= NP);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    detect_add = 0; data_in = '0; write_enb_reg = 0; clr_sticky = 0;
    read_enb = '0; full = '0; empty = '1;
    detect_add4 = 0; data_in4 = '0; write_enb_reg4 = 0; clr_sticky4 = 0;
    read_enb4 = '0; full4 = '0; empty4 = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_cycle();
    logic [W-1:0] act, exp;
    @(negedge clk);
    detect_add    = ($urandom_range(0, 3) == 0);
    data_in       = AW'($urandom_range(0, 3));
    write_enb_reg = ($urandom_range(0, 1) == 1);
    full          = NP'($urandom);
    clr_sticky    = ($urandom_range(0, 19) == 0);
    for (int k = 0; k < NP; k++) begin
      if ($urandom_range(0, 39) == 0) empty[k] = ~empty[k];
      read_enb[k] = ($urandom_range(0, 15) == 0);
    end
    #1;
    exp_q.push_back(model_expect());
    act = {write_enb, fifo_full, addr_err, sft_rst, timeout_sticky, vld_out};
    exp = exp_q.pop_front();
    chk("rand_cycle", 32'(act), 32'(exp));
    @(posedge clk);
    model_edge();
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic       det;
    logic [1:0] d;
    logic       we;
    logic [2:0] fu;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic       exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd3, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0};

    idle_inputs();
    model_reset();

    // Reset state
    do_reset();
    #1;
    chk("reset_sft_rst", 32'(sft_rst), 32'(3'b000));
    chk("reset_sticky", 32'(timeout_sticky), 32'(3'b000));
    chk("reset_addr_err", 32'(addr_err), 32'(1'b0));
    chk("reset_vld_out", 32'(vld_out), 32'(3'b000));

    // Table-driven address decode and full mux
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      detect_add = tbl[i].det; data_in = tbl[i].d;
      write_enb_reg = tbl[i].we; full = tbl[i].fu;
      #1;
      chk($sformatf("tbl%0d_write_enb", i), 32'(write_enb), 32'(tbl[i].exp_we));
      chk($sformatf("tbl%0d_fifo_full", i), 32'(fifo_full), 32'(tbl[i].exp_ff));
      chk($sformatf("tbl%0d_addr_err", i), 32'(addr_err), 32'(tbl[i].exp_err));
      @(posedge clk);
    end

    // Timeout on port 1: pulse after the 30th idle edge only
    do_reset();
    @(negedge clk);
    empty = 3'b101;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk); #1;
      chk($sformatf("to1_edge%0d_sft", e), 32'(sft_rst), 32'((e == 30) ? 3'b010 : 3'b000));
    end
    chk("to1_sticky", 32'(timeout_sticky), 32'(3'b010));

    // Read on the would-be 30th edge suppresses the pulse and restarts counting
    do_reset();
    @(negedge clk);
    empty = 3'b101;
    repeat (29) @(posedge clk);
    @(negedge clk);
    read_enb = 3'b010;
    @(posedge clk); #1;
    chk("read_edge30_sft", 32'(sft_rst), 32'(3'b000));
    @(negedge clk);
    read_enb = 3'b000;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      chk($sformatf("after_read_edge%0d_sft", e), 32'(sft_rst), 32'((e == 30) ? 3'b010 : 3'b000));
    end
    chk("after_read_sticky", 32'(timeout_sticky), 32'(3'b010));

    // Simultaneous timeouts on ports 0 and 2 with clr_sticky that cycle
    do_reset();
    @(negedge clk);
    empty = 3'b010;
    repeat (29) @(posedge clk);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("simul_sft", 32'(sft_rst), 32'(3'b101));
    chk("simul_sticky_set_wins", 32'(timeout_sticky), 32'(3'b101));
    @(posedge clk); #1;
    chk("simul_sft_done", 32'(sft_rst), 32'(3'b000));
    chk("simul_sticky_cleared", 32'(timeout_sticky), 32'(3'b000));
    clr_sticky = 1'b0;

    // Asynchronous reset mid-operation: addr_q=1, cnt_0=10, sticky[2] set
    do_reset();
    @(negedge clk);
    empty = 3'b011; detect_add = 1'b1; data_in = 2'd1;
    @(negedge clk);
    detect_add = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    empty = 3'b010;
    repeat (10) @(posedge clk);
    @(negedge clk);
    write_enb_reg = 1'b1;
    #1;
    chk("pre_rst_write_enb", 32'(write_enb), 32'(3'b010));
    chk("pre_rst_sticky", 32'(timeout_sticky), 32'(3'b100));
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_write_enb", 32'(write_enb), 32'(3'b000));
    chk("async_rst_sft", 32'(sft_rst), 32'(3'b000));
    chk("async_rst_sticky", 32'(timeout_sticky), 32'(3'b000));
    chk("async_rst_addr_err", 32'(addr_err), 32'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    write_enb_reg = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_edge%0d_sft", e), 32'(sft_rst), 32'((e == 30) ? 3'b101 : 3'b000));
    end

    // Asynchronous reset clears a set addr_err
    do_reset();
    @(negedge clk);
    detect_add = 1'b1; data_in = 2'd3;
    @(negedge clk);
    detect_add = 1'b0;
    #1;
    chk("err_before_rst", 32'(addr_err), 32'(1'b1));
    #1;
    rst = 1'b0;
    #1;
    chk("err_async_rst", 32'(addr_err), 32'(1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Four-port instance, TIMEOUT=2
    do_reset();
    @(negedge clk);
    detect_add4 = 1'b1; data_in4 = 2'd3;
    @(negedge clk);
    detect_add4 = 1'b0; write_enb_reg4 = 1'b1; full4 = 4'b1000;
    #1;
    chk("p4_write_enb", 32'(write_enb4), 32'(4'b1000));
    chk("p4_addr_err", 32'(addr_err4), 32'(1'b0));
    chk("p4_fifo_full", 32'(fifo_full4), 32'(1'b1));
    @(negedge clk);
    write_enb_reg4 = 1'b0; empty4 = 4'b0111;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk($sformatf("p4_edge%0d_sft", e), 32'(sft_rst4),
          32'(((e == 2) || (e == 4)) ? 4'b1000 : 4'b0000));
    end
    chk("p4_sticky", 32'(timeout_sticky4), 32'(4'b1000));

    // Random traffic against the model
    do_reset();
    repeat (3000) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
